coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front end of the vending datapath; produces the 2-bit money code that Vending_Machine samples on every clk edge.
- Takes three raw mechanical coin-sensor lines and conditions them: synchronizes, debounces, edge-detects and queues them.
- Each coin is issued as exactly one cycle of a non-zero money code, followed by at least GAP_CYCLES cycles of 2'b00, so the downstream FSM advances once per coin.
- Issue is deferred while the machine is dispensing or returning change.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized line must disagree with its debounced level before that level flips (>=1)
DEPTH, 4, FIFO entries for queued coin codes (power of 2, >=2)
GAP_CYCLES, 1, minimum cycles of money=2'b00 after every issued code (>=1)
JAM_CYCLES, 64, cycles a debounced line may stay high before jam is flagged (only with JAM_DETECT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
coin_in  input  3  raw asynchronous sensor lines; bit0 -> code 2'b01, bit1 -> 2'b10, bit2 -> 2'b11
hold  input  1  driven by dispense|change; blocks starting a new issue
money  output  2  registered money code to Vending_Machine; 2'b00 = no coin
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
coin_reject  output  1  one-cycle pulse when a coin event is dropped
jam  output  3  per-line jam flags (only with JAM_DETECT_EN)

Behaviour:
- One clock. Reset is synchronous and active-high (rst, sampled on clk rising edge).
- Reset values: money=00, coin_reject=0, fifo_count=0, jam=000. Synchronizers, debounced levels, counters, pending bits and FIFO are all cleared; FSM goes to IDLE.
- Reset mid-issue: money returns to 00 on the reset edge. The queued coin is lost.
- Synchronizer: two flops per line.
- Debounce: per-line counter counts consecutive cycles where the synchronized value differs from the debounced level.
  - Counter clears on any agreeing cycle.
  - The level flips on the edge where the count reaches DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Event: a 0->1 transition of a debounced level sets pending[i]. 1->0 transitions produce nothing.
- Pending to FIFO: each cycle, if FIFO not full, the lowest-index set pending bit is cleared and its code is written to the FIFO. This takes at most one write per cycle.
- Simultaneous events on several lines are serialized in bit order 0,1,2.
- A new event on line i while pending[i] is already set: the event is dropped and coin_reject pulses for 1 cycle. pending[i] stays set.
- FIFO full: pending bits wait; nothing is dropped unless the rule above applies.
- Output FSM (money registered):
  - IDLE: money=00. If FIFO not empty and hold=0, pop; money=entry on the next edge; go to SEND.
  - SEND: one cycle with money=entry; then go to GAP with money=00.
  - GAP: money=00 for GAP_CYCLES cycles; then go to IDLE.
- hold is examined only in IDLE. An issue already in SEND is never aborted.
- Latency with FIFO empty and hold=0: a clean rising edge on coin_in first sampled at edge k gives money valid after edge k+DEBOUNCE_CYCLES+5. Stages: 2 sync, DEBOUNCE_CYCLES debounce, 1 pending, 1 FIFO, 1 output.
- Throughput: one coin per 1+GAP_CYCLES cycles.
- fifo_count changes in the same cycle as a write or pop. A simultaneous write and pop leaves the count unchanged.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro JAM_DETECT_EN.
- Defined:
  - Per-line counter of consecutive cycles with debounced level high.
  - Reaching JAM_CYCLES sets jam[i].
  - jam[i] clears when line i debounces low.
  - While any jam bit is set, new events on all lines are ignored. They do not set pending and do not pulse coin_reject.
  - Entries already queued still issue.
- Not defined: jam port absent, no jam counters, no event blocking.

Test Plan:
- Reset, then coin_in=001 held clean 20 cycles -> money=01 for exactly 1 cycle at edge DEBOUNCE_CYCLES+5 after first sample, then 00; fifo_count returns to 0.
- Bounce: coin_in[1] toggles 1-cycle pulses for 10 cycles, then settles high -> exactly one money=10 issue, no coin_reject.
- coin_in=111 rises in one cycle -> money sequence 01,00,10,00,11,00 (GAP_CYCLES=1), each code 1 cycle.
- hold=1 for 12 cycles while two coins are queued -> money stays 00, fifo_count=2; after hold drops, codes issue in arrival order.
- DEPTH=4: inject 6 coins on line 0 spaced just beyond debounce with hold=1 -> fifo_count saturates at 4, pending holds 1, coin_reject pulses once; after hold drops, 5 issues of 01.
- rst asserted during SEND with 3 entries queued -> money=00 on next edge, fifo_count=0, no further issues. With JAM_DETECT_EN: coin_in[2] high 70 cycles -> jam=100, an event on line 0 is ignored, jam clears after line 2 drops.

Source files
------------

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module   : coin_acceptor
//  Purpose  : Front end of the vending datapath. Conditions three raw
//             mechanical coin-sensor lines and issues one registered money
//             code per coin to Vending_Machine.
//             The conditioning chain is: 2-flop synchronizer, debounce,
//             registered rising-edge detect, pending latch, FIFO, and an
//             output sequencer.
//             Each coin appears on money for exactly one cycle. It is followed
//             by at least GAP_CYCLES cycles of 2'b00.
//             A new issue does not start while hold (dispense | change) is high.
//
//  Ports    : clk          system clock
//             rst          synchronous, active-high reset
//             coin_in[2:0] raw asynchronous sensor lines
//                          (bit0 -> 2'b01, bit1 -> 2'b10, bit2 -> 2'b11)
//             hold         blocks starting a new issue
//             money[1:0]   registered money code, 2'b00 = no coin
//             fifo_count   current FIFO occupancy
//             coin_reject  one-cycle pulse when a coin event is dropped
//             jam[2:0]     per-line jam flags (JAM_DETECT_EN builds only)
//
//  Options  : `define JAM_DETECT_EN enables per-line jam detection and the jam
//             port. While any line is jammed, new coin events are ignored.
//
//  Revision : 1.0  initial release
// ============================================================================
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEPTH           = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int JAM_CYCLES      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               coin_in,
    input  logic                     hold,
    output logic [1:0]               money,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     coin_reject
`ifdef JAM_DETECT_EN
    ,
    output logic [2:0]               jam
`endif
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_CW  = c_AW + 1;
    localparam int c_DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_GW  = $clog2(GAP_CYCLES + 1);

    // The counter holds (count - 1) when a flip is due.
    // When it sits at c_DB_LAST and the line still disagrees, this edge is the
    // one on which the count reaches DEBOUNCE_CYCLES.
    localparam logic [c_DBW-1:0] c_DB_LAST   = c_DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(DEPTH);
    localparam logic [c_GW-1:0]  c_GAP_LAST  = c_GW'(GAP_CYCLES - 1);
    localparam logic [c_GW-1:0]  c_GAP_FIRST = c_GW'(1);

    // Output sequencer encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer per sensor line
    // ------------------------------------------------------------------------
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= coin_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce: count consecutive disagreeing cycles.
    // Any agreeing cycle restarts the count. The debounced level follows the
    // synchronized line only after DEBOUNCE_CYCLES disagreeing cycles in a row.
    // ------------------------------------------------------------------------
    logic [c_DBW-1:0] r_db_cnt [3];
    logic [2:0]       r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_level[i]  <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered rising-edge detect on the debounced levels.
    // Only 0->1 transitions are coin events.
    // ------------------------------------------------------------------------
    logic [2:0] r_level_d;
    logic [2:0] r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= '0;
            r_rise    <= '0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional jam detection
    // ------------------------------------------------------------------------
    logic w_jam_any;

`ifdef JAM_DETECT_EN
    localparam int               c_JW       = $clog2(JAM_CYCLES + 1);
    localparam logic [c_JW-1:0]  c_JAM_MAX  = c_JW'(JAM_CYCLES);
    localparam logic [c_JW-1:0]  c_JAM_LAST = c_JW'(JAM_CYCLES - 1);

    logic [c_JW-1:0] r_jam_cnt [3];
    logic [2:0]      r_jam;

    // Counts cycles with the debounced level high and saturates at JAM_CYCLES.
    // The flag clears only once the line has debounced low again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_jam <= '0;
            for (int i = 0; i < 3; i++) begin
                r_jam_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!r_level[i]) begin
                    r_jam_cnt[i] <= '0;
                    r_jam[i]     <= 1'b0;
                end else if (r_jam_cnt[i] != c_JAM_MAX) begin
                    r_jam_cnt[i] <= r_jam_cnt[i] + 1'b1;
                    if (r_jam_cnt[i] == c_JAM_LAST) begin
                        r_jam[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign jam       = r_jam;
    assign w_jam_any = |r_jam;
`else
    // Without jam detection, events are never blocked.
    // JAM_CYCLES is kept only so that both builds share one parameter list.
    assign w_jam_any = (JAM_CYCLES < 0);
`endif

    // ------------------------------------------------------------------------
    // Pending latch and transfer into the FIFO
    // ------------------------------------------------------------------------
    logic [2:0]      r_pending;
    logic [2:0]      w_event;
    logic [2:0]      w_sel;
    logic [2:0]      w_clr;
    logic [2:0]      w_rej;
    logic            w_wr;
    logic            w_pop;
    logic [1:0]      w_wr_code;
    logic [c_CW-1:0] r_count;
    logic            r_reject;

    assign w_event = r_rise & ~{3{w_jam_any}};

    // Lowest-index set bit, so that simultaneous coins go out in order 0,1,2
    assign w_sel = r_pending & (~r_pending + 3'd1);
    assign w_wr  = (|r_pending) && (r_count != c_FULL);
    assign w_clr = w_wr ? w_sel : 3'b000;

    // A line whose pending bit is moving into the FIFO this cycle can accept a
    // fresh event, so only a pending bit that stays occupied rejects the event.
    assign w_rej = w_event & r_pending & ~w_clr;

    always_comb begin
        w_wr_code = 2'b11;
        if (w_sel[0]) begin
            w_wr_code = 2'b01;
        end else if (w_sel[1]) begin
            w_wr_code = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_reject  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_event;
            r_reject  <= |w_rej;
        end
    end

    // ------------------------------------------------------------------------
    // Coin-code FIFO. Pointers wrap naturally because DEPTH is a power of 2.
    // ------------------------------------------------------------------------
    logic [1:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'b00;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_wr_code;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output sequencer
    // The first idle cycle after SEND already drives 2'b00, so it counts as
    // the first gap cycle. GAP holds the remaining GAP_CYCLES-1 cycles.
    // This gives one coin every 1+GAP_CYCLES cycles.
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [1:0]      r_money;
    logic [1:0]      w_money_next;
    logic [c_GW-1:0] r_gap_cnt;
    logic [c_GW-1:0] w_gap_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_money   <= 2'b00;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_money   <= w_money_next;
            r_gap_cnt <= w_gap_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_money_next   = 2'b00;
        w_gap_cnt_next = r_gap_cnt;
        w_pop          = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // hold is honoured only here; a started issue always completes
                if ((r_count != '0) && !hold) begin
                    w_pop        = 1'b1;
                    w_money_next = r_mem[r_rptr];
                    w_state_next = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                w_gap_cnt_next = c_GAP_FIRST;
                w_state_next   = (GAP_CYCLES > 1) ? c_ST_GAP : c_ST_IDLE;
            end
            c_ST_GAP: begin
                if (r_gap_cnt >= c_GAP_LAST) begin
                    w_state_next = c_ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    assign money       = r_money;
    assign fifo_count  = r_count;
    assign coin_reject = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coin_acceptor
//  Purpose  : Self-checking bench for coin_acceptor. Expected money codes are
//             queued as coins are driven. A negedge monitor pops the queue and
//             compares each issued code, and checks the 00 gap after it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coin_acceptor;

    localparam int c_DB    = 4;
    localparam int c_DEPTH = 4;
    localparam int c_GAP   = 1;
    localparam int c_JAM   = 64;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [2:0]                 coin_in = 3'b000;
    logic                       hold = 1'b0;
    logic [1:0]                 money;
    logic [$clog2(c_DEPTH):0]   fifo_count;
    logic                       coin_reject;
`ifdef JAM_DETECT_EN
    logic [2:0]                 jam;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         issue_count  = 0;
    int         reject_count = 0;
    logic [1:0] exp_q [$];
    int         issue_cyc [$];
    logic [1:0] prev_money = 2'b00;
    logic [1:0] mon_exp;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (c_DB),
        .DEPTH           (c_DEPTH),
        .GAP_CYCLES      (c_GAP),
        .JAM_CYCLES      (c_JAM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_in     (coin_in),
        .hold        (hold),
        .money       (money),
        .fifo_count  (fifo_count),
        .coin_reject (coin_reject)
`ifdef JAM_DETECT_EN
        ,
        .jam         (jam)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (prev_money != 2'b00) begin
            n_tests++;
            if (money !== 2'b00) begin
                n_fail++;
                $display("FAIL gap_after_issue: money=%b, required 00 (cycle %0d)", money, cyc);
            end
        end
        if (money !== 2'b00) begin
            issue_count++;
            issue_cyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue: money=%b, required no issue (cycle %0d)", money, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (money !== mon_exp) begin
                    n_fail++;
                    $display("FAIL issue_code: money=%b, required %b (cycle %0d)", money, mon_exp, cyc);
                end
            end
        end
        if (coin_reject === 1'b1) reject_count++;
        prev_money = money;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drives a clean pulse on the given lines, long enough to debounce high
    // and then low again.
    task automatic pulse(input logic [2:0] lines);
        coin_in = lines;
        step(c_DB + 3);
        coin_in = 3'b000;
        step(c_DB + 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_tests++; if (money !== 2'b00) begin n_fail++; $display("FAIL reset_money: got %b, required 00", money); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count); end
        n_tests++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b, required 0", coin_reject); end
`ifdef JAM_DETECT_EN
        n_tests++; if (jam !== 3'b000) begin n_fail++; $display("FAIL reset_jam: got %b, required 000", jam); end
`endif
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_latency();
        int k;
        coin_in = 3'b001;
        exp_q.push_back(2'b01);
        k = cyc + 1;
        wait_until(k + c_DB + 4);
        n_tests++; if (money !== 2'b00) begin n_fail++; $display("FAIL latency_early: money=%b, required 00", money); end
        step(1);
        n_tests++; if (money !== 2'b01) begin n_fail++; $display("FAIL latency_issue: money=%b, required 01", money); end
        step(1);
        n_tests++; if (money !== 2'b00) begin n_fail++; $display("FAIL latency_after: money=%b, required 00", money); end
        step(15);
        coin_in = 3'b000;
        step(20);
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL latency_fifo_empty: got %0d, required 0", fifo_count); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL latency_outstanding: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_bounce();
        int iss0, rej0;
        iss0 = issue_count;
        rej0 = reject_count;
        exp_q.push_back(2'b10);
        for (int i = 0; i < 10; i++) begin
            coin_in = (i % 2 == 0) ? 3'b010 : 3'b000;
            step(1);
        end
        coin_in = 3'b010;
        step(20);
        coin_in = 3'b000;
        step(20);
        n_tests++; if (issue_count - iss0 != 1) begin n_fail++; $display("FAIL bounce_issues: got %0d, required 1", issue_count - iss0); end
        n_tests++; if (reject_count != rej0) begin n_fail++; $display("FAIL bounce_reject: got %0d, required 0", reject_count - rej0); end
    endtask

    task automatic test_simultaneous();
        issue_cyc.delete();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b11);
        coin_in = 3'b111;
        step(25);
        coin_in = 3'b000;
        step(20);
        n_tests++; if (issue_cyc.size() != 3) begin n_fail++; $display("FAIL simul_count: got %0d, required 3", issue_cyc.size()); end
        if (issue_cyc.size() == 3) begin
            n_tests++; if (issue_cyc[1] - issue_cyc[0] != 1 + c_GAP) begin n_fail++; $display("FAIL simul_spacing01: got %0d, required %0d", issue_cyc[1] - issue_cyc[0], 1 + c_GAP); end
            n_tests++; if (issue_cyc[2] - issue_cyc[1] != 1 + c_GAP) begin n_fail++; $display("FAIL simul_spacing12: got %0d, required %0d", issue_cyc[2] - issue_cyc[1], 1 + c_GAP); end
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_outstanding: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_hold();
        int   iss0;
        logic leak;
        iss0 = issue_count;
        leak = 1'b0;
        hold = 1'b1;
        coin_in = 3'b010;
        exp_q.push_back(2'b10);
        step(10);
        coin_in = 3'b011;
        exp_q.push_back(2'b01);
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (money !== 2'b00) leak = 1'b1;
        end
        n_tests++; if (leak !== 1'b0) begin n_fail++; $display("FAIL hold_leak: got issue during hold, required none"); end
        n_tests++; if (fifo_count !== 2) begin n_fail++; $display("FAIL hold_fifo_count: got %0d, required 2", fifo_count); end
        hold = 1'b0;
        coin_in = 3'b000;
        step(20);
        n_tests++; if (issue_count - iss0 != 2) begin n_fail++; $display("FAIL hold_issues: got %0d, required 2", issue_count - iss0); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_outstanding: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        int iss0, rej0;
        iss0 = issue_count;
        rej0 = reject_count;
        hold = 1'b1;
        for (int n = 0; n < 6; n++) begin
            pulse(3'b001);
            if (n < 5) exp_q.push_back(2'b01);
        end
        step(10);
        n_tests++; if (fifo_count !== c_DEPTH) begin n_fail++; $display("FAIL overflow_fifo_count: got %0d, required %0d", fifo_count, c_DEPTH); end
        n_tests++; if (reject_count - rej0 != 1) begin n_fail++; $display("FAIL overflow_reject: got %0d, required 1", reject_count - rej0); end
        hold = 1'b0;
        step(30);
        n_tests++; if (issue_count - iss0 != 5) begin n_fail++; $display("FAIL overflow_issues: got %0d, required 5", issue_count - iss0); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL overflow_drain: got %0d, required 0", fifo_count); end
    endtask

    task automatic test_reset_mid_issue();
        int iss0;
        int t;
        hold = 1'b1;
        for (int n = 0; n < 4; n++) pulse(3'b001);
        step(5);
        n_tests++; if (fifo_count !== 4) begin n_fail++; $display("FAIL rstmid_queued: got %0d, required 4", fifo_count); end
        exp_q.push_back(2'b01);
        hold = 1'b0;
        t = 0;
        while (money === 2'b00 && t < 10) begin
            step(1);
            t++;
        end
        n_tests++; if (money === 2'b00) begin n_fail++; $display("FAIL rstmid_timeout: no issue within 10 cycles, required one"); end
        rst = 1'b1;
        step(1);
        n_tests++; if (money !== 2'b00) begin n_fail++; $display("FAIL rstmid_money: got %b, required 00", money); end
        n_tests++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rstmid_fifo: got %0d, required 0", fifo_count); end
        rst = 1'b0;
        iss0 = issue_count;
        step(20);
        n_tests++; if (issue_count != iss0) begin n_fail++; $display("FAIL rstmid_issues: got %0d, required 0", issue_count - iss0); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_outstanding: got %0d, required 0", exp_q.size()); end
    endtask

`ifdef JAM_DETECT_EN
    task automatic test_jam();
        int iss0, rej0;
        iss0 = issue_count;
        rej0 = reject_count;
        exp_q.push_back(2'b11);
        coin_in = 3'b100;
        step(75);
        n_tests++; if (jam !== 3'b100) begin n_fail++; $display("FAIL jam_set: got %b, required 100", jam); end
        coin_in = 3'b101;
        step(c_DB + 3);
        coin_in = 3'b100;
        step(10);
        n_tests++; if (issue_count - iss0 != 1) begin n_fail++; $display("FAIL jam_blocked: got %0d issues, required 1", issue_count - iss0); end
        n_tests++; if (reject_count != rej0) begin n_fail++; $display("FAIL jam_reject: got %0d, required 0", reject_count - rej0); end
        coin_in = 3'b000;
        step(c_DB + 6);
        n_tests++; if (jam !== 3'b000) begin n_fail++; $display("FAIL jam_clear: got %b, required 000", jam); end
        step(10);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_simultaneous();
        test_hold();
        test_overflow();
        test_reset_mid_issue();
`ifdef JAM_DETECT_EN
        test_jam();
`endif
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_outstanding: got %0d, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
